// File: rtl/fixed_point_acc_multilane_if.sv
// Handshake bundle for fixed_point_acc_multilane: operand vector and bias in,
// narrowed result and overflow flag out, ready/valid on both sides.
interface fixed_point_acc_multilane_if #(
    parameter int WIDTH      = 8,
    parameter int NUM_INPUTS = 16
);
    logic [NUM_INPUTS*WIDTH-1:0] VALUES_IN;
    logic [WIDTH-1:0]            EXT_VALUE_IN;
    logic                        VALID_IN;
    logic                        READY_OUT;
    logic [WIDTH-1:0]            VALUE_OUT;
    logic                        VALID_OUT;
    logic                        READY_IN;
    logic                        OVERFLOW;

    modport master (
        output VALUES_IN, EXT_VALUE_IN, VALID_IN, READY_IN,
        input  READY_OUT, VALUE_OUT, VALID_OUT, OVERFLOW
    );

    modport slave (
        input  VALUES_IN, EXT_VALUE_IN, VALID_IN, READY_IN,
        output READY_OUT, VALUE_OUT, VALID_OUT, OVERFLOW
    );
endinterface

// File: rtl/fixed_point_acc_multilane.sv
// Multi-lane fixed-point reduction: LANES operands per cycle into a widened accumulator,
// then saturating or wrapping narrowing. Define FIXED_POINT_ACC_MULTILANE_RELU_EN to add a ReLU.
module fixed_point_acc_multilane_lane #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 12,
    parameter int DEPTH = 16,
    parameter int LANES = 4,
    parameter int LANE  = 0,
    parameter int CW    = 2
) (
    input  logic [CW-1:0]                 chunk,
    input  logic [DEPTH-1:0][WIDTH-1:0]   pad,
    output logic signed [ACC_W-1:0]       term
);
    int         idx;
    logic [WIDTH-1:0] op;

    always_comb begin
        idx = int'(chunk) * LANES + LANE;
        op  = '0;
        for (int k = 0; k < DEPTH; k++)
            if (k == idx) op = pad[k];
        term = ACC_W'($signed(op));
    end
endmodule

module fixed_point_acc_multilane #(
    parameter int WIDTH        = 8,
    parameter int FRAC_BITS    = 3,
    parameter int NUM_INPUTS   = 16,
    parameter int LANES        = 4,
    parameter int HAS_EXT_BIAS = 0,
    parameter int SATURATE     = 1
) (
    input  logic                           CLK,
    input  logic                           RST,
    fixed_point_acc_multilane_if.slave     bus
);
    localparam int NI    = NUM_INPUTS + ((HAS_EXT_BIAS != 0) ? 1 : 0);
    localparam int C     = (NI + LANES - 1) / LANES;
    localparam int ACC_W = WIDTH + $clog2(NI);
    localparam int DEPTH = C * LANES;
    localparam int CW    = (C > 1) ? $clog2(C) : 1;
    localparam logic [CW-1:0] LAST = CW'(C - 1);
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUMULATE, DONE} state_t;

    state_t                          state_q, state_d;
    logic [DEPTH-1:0][WIDTH-1:0]     pad_d, pad_q;
    logic [LANES-1:0][ACC_W-1:0]     terms;
    logic [CW-1:0]                   chunk_q;
    logic signed [ACC_W-1:0]         acc_q, sum, acc_nx;
    logic                            hi, lo;
    logic [WIDTH-1:0]                res, value_q;
    logic                            ovf_q;

    // Operand slots past the real inputs (and bias) are constant zero padding.
    for (genvar i = 0; i < DEPTH; i++) begin : g_pad
        if (i < NUM_INPUTS) begin : g_val
            assign pad_d[i] = bus.VALUES_IN[i*WIDTH +: WIDTH];
        end else if (i == NUM_INPUTS && HAS_EXT_BIAS != 0) begin : g_bias
            assign pad_d[i] = bus.EXT_VALUE_IN;
        end else begin : g_zero
            assign pad_d[i] = '0;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        fixed_point_acc_multilane_lane #(
            .WIDTH(WIDTH), .ACC_W(ACC_W), .DEPTH(DEPTH),
            .LANES(LANES), .LANE(l), .CW(CW)
        ) u_lane (
            .chunk (chunk_q),
            .pad   (pad_q),
            .term  (terms[l])
        );
    end

    always_comb begin
        sum = '0;
        for (int l = 0; l < LANES; l++) sum = sum + terms[l];
        acc_nx = acc_q + sum;
        hi     = acc_nx > MAXV;
        lo     = acc_nx < MINV;
        res    = acc_nx[WIDTH-1:0];
        if (SATURATE != 0) begin
            if (hi)      res = {1'b0, {(WIDTH-1){1'b1}}};
            else if (lo) res = {1'b1, {(WIDTH-1){1'b0}}};
        end
`ifdef FIXED_POINT_ACC_MULTILANE_RELU_EN
        if (res[WIDTH-1]) res = '0;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        bus.READY_OUT = 1'b0;
        bus.VALID_OUT = 1'b0;
        case (state_q)
            IDLE: begin
                bus.READY_OUT = 1'b1;
                if (bus.VALID_IN) state_d = ACCUMULATE;
            end
            ACCUMULATE: if (chunk_q == LAST) state_d = DONE;
            DONE: begin
                bus.VALID_OUT = 1'b1;
                if (bus.READY_IN) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pad_q   <= '0;
            acc_q   <= '0;
            chunk_q <= '0;
            value_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.VALID_IN) begin
                    pad_q   <= pad_d;
                    acc_q   <= '0;
                    chunk_q <= '0;
                    value_q <= '0;
                    ovf_q   <= 1'b0;
                end
                ACCUMULATE: begin
                    acc_q   <= acc_nx;
                    chunk_q <= chunk_q + 1'b1;
                    if (chunk_q == LAST) begin
                        value_q <= res;
                        ovf_q   <= hi | lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.VALUE_OUT = value_q;
    assign bus.OVERFLOW  = ovf_q;
endmodule

// File: tb/tb_fixed_point_acc_multilane.sv
// Bench for fixed_point_acc_multilane: four configurations share one stimulus stream,
// per-DUT scoreboards hold the modelled results.
module tb_fixed_point_acc_multilane;
    typedef struct {
        logic [7:0] v;
        logic       o;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RST;
    logic [127:0] vals;
    logic [7:0]   ext;
    logic         vin, rin;
    logic         rdy [4];
    logic         vld [4];
    logic         ovf [4];
    logic [7:0]   vo  [4];
    exp_t         sbq [4][$];
    int           n_checks = 0;
    int           n_fail   = 0;

    always #5 CLK = ~CLK;

    fixed_point_acc_multilane_if #(.WIDTH(8), .NUM_INPUTS(16)) if0 ();
    fixed_point_acc_multilane_if #(.WIDTH(8), .NUM_INPUTS(16)) if1 ();
    fixed_point_acc_multilane_if #(.WIDTH(8), .NUM_INPUTS(16)) if2 ();
    fixed_point_acc_multilane_if #(.WIDTH(8), .NUM_INPUTS(16)) if3 ();

    assign if0.VALUES_IN = vals; assign if0.EXT_VALUE_IN = ext; assign if0.VALID_IN = vin; assign if0.READY_IN = rin;
    assign if1.VALUES_IN = vals; assign if1.EXT_VALUE_IN = ext; assign if1.VALID_IN = vin; assign if1.READY_IN = rin;
    assign if2.VALUES_IN = vals; assign if2.EXT_VALUE_IN = ext; assign if2.VALID_IN = vin; assign if2.READY_IN = rin;
    assign if3.VALUES_IN = vals; assign if3.EXT_VALUE_IN = ext; assign if3.VALID_IN = vin; assign if3.READY_IN = rin;

    assign rdy[0] = if0.READY_OUT; assign vld[0] = if0.VALID_OUT; assign ovf[0] = if0.OVERFLOW; assign vo[0] = if0.VALUE_OUT;
    assign rdy[1] = if1.READY_OUT; assign vld[1] = if1.VALID_OUT; assign ovf[1] = if1.OVERFLOW; assign vo[1] = if1.VALUE_OUT;
    assign rdy[2] = if2.READY_OUT; assign vld[2] = if2.VALID_OUT; assign ovf[2] = if2.OVERFLOW; assign vo[2] = if2.VALUE_OUT;
    assign rdy[3] = if3.READY_OUT; assign vld[3] = if3.VALID_OUT; assign ovf[3] = if3.OVERFLOW; assign vo[3] = if3.VALUE_OUT;

    // 0: saturate, 4 lanes; 1: wrap, 4 lanes; 2: bias, 4 lanes (C=5); 3: bias, 17 lanes (C=1)
    fixed_point_acc_multilane #(.WIDTH(8), .FRAC_BITS(3), .NUM_INPUTS(16), .LANES(4),
        .HAS_EXT_BIAS(0), .SATURATE(1)) u_dut0 (.CLK(CLK), .RST(RST), .bus(if0));
    fixed_point_acc_multilane #(.WIDTH(8), .FRAC_BITS(3), .NUM_INPUTS(16), .LANES(4),
        .HAS_EXT_BIAS(0), .SATURATE(0)) u_dut1 (.CLK(CLK), .RST(RST), .bus(if1));
    fixed_point_acc_multilane #(.WIDTH(8), .FRAC_BITS(3), .NUM_INPUTS(16), .LANES(4),
        .HAS_EXT_BIAS(1), .SATURATE(1)) u_dut2 (.CLK(CLK), .RST(RST), .bus(if2));
    fixed_point_acc_multilane #(.WIDTH(8), .FRAC_BITS(3), .NUM_INPUTS(16), .LANES(17),
        .HAS_EXT_BIAS(1), .SATURATE(1)) u_dut3 (.CLK(CLK), .RST(RST), .bus(if3));

    function automatic int lat_of(input int d);
        return (d == 2) ? 6 : (d == 3) ? 2 : 5;
    endfunction

    function automatic exp_t model(input int d, input logic [127:0] v, input logic [7:0] e);
        exp_t x;
        int   s;
        s = 0;
        for (int i = 0; i < 16; i++) s += int'($signed(v[i*8 +: 8]));
        if (d >= 2) s += int'($signed(e));
        x.o = (s > 127) || (s < -128);
        x.v = s[7:0];
        if (d != 1) begin
            if (s > 127)       x.v = 8'h7F;
            else if (s < -128) x.v = 8'h80;
        end
`ifdef FIXED_POINT_ACC_MULTILANE_RELU_EN
        if (x.v[7]) x.v = 8'h00;
`endif
        return x;
    endfunction

    function automatic logic [127:0] fill(input logic [7:0] a, input logic [7:0] b);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = (i % 2 == 0) ? a : b;
        return r;
    endfunction

    task automatic test_reset();
        RST = 1'b1; vin = 1'b0; rin = 1'b1; vals = '0; ext = 8'hF8;
        repeat (3) @(posedge CLK);
        @(negedge CLK); RST = 1'b0;
        @(negedge CLK);
        for (int d = 0; d < 4; d++) begin
            n_checks += 4;
            if (rdy[d] !== 1'b1)  begin n_fail++; $display("FAIL reset_ready dut%0d got %b want 1", d, rdy[d]); end
            if (vld[d] !== 1'b0)  begin n_fail++; $display("FAIL reset_valid dut%0d got %b want 0", d, vld[d]); end
            if (vo[d]  !== 8'h00) begin n_fail++; $display("FAIL reset_value dut%0d got %h want 00", d, vo[d]); end
            if (ovf[d] !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf dut%0d got %b want 0", d, ovf[d]); end
        end
    endtask

    // One transaction with READY_IN high; checks latency, value, flag and READY_OUT timing.
    task automatic test_txn(input string name, input logic [127:0] v, input logic [7:0] e);
        bit   seen [4];
        exp_t x;
        @(negedge CLK);
        vals = v; ext = e; vin = 1'b1; rin = 1'b1;
        for (int d = 0; d < 4; d++) begin
            seen[d] = 1'b0;
            sbq[d].push_back(model(d, v, e));
        end
        @(posedge CLK); #1 vin = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge CLK);
            for (int d = 0; d < 4; d++) begin
                n_checks++;
                if (rdy[d] !== (cyc > lat_of(d))) begin
                    n_fail++;
                    $display("FAIL %s_ready dut%0d cycle %0d got %b want %b", name, d, cyc, rdy[d], cyc > lat_of(d));
                end
                if (vld[d] === 1'b1 && !seen[d]) begin
                    seen[d] = 1'b1;
                    n_checks++;
                    if (sbq[d].size() == 0) begin
                        n_fail++; $display("FAIL %s_unexpected dut%0d cycle %0d", name, d, cyc);
                    end else begin
                        x = sbq[d].pop_front();
                        n_checks += 2;
                        if (cyc != lat_of(d)) begin n_fail++; $display("FAIL %s_latency dut%0d got %0d want %0d", name, d, cyc, lat_of(d)); end
                        if (vo[d] !== x.v)    begin n_fail++; $display("FAIL %s_value dut%0d got %h want %h", name, d, vo[d], x.v); end
                        if (ovf[d] !== x.o)   begin n_fail++; $display("FAIL %s_ovf dut%0d got %b want %b", name, d, ovf[d], x.o); end
                    end
                end
            end
        end
        for (int d = 0; d < 4; d++) begin
            if (!seen[d]) begin
                n_checks++; n_fail++;
                $display("FAIL %s_timeout dut%0d no VALID_OUT", name, d);
                void'(sbq[d].pop_front());
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t xs [4];
        @(negedge CLK);
        vals = fill(8'h06, 8'hFD); ext = 8'h09; vin = 1'b1; rin = 1'b0;
        for (int d = 0; d < 4; d++) sbq[d].push_back(model(d, vals, ext));
        @(posedge CLK); #1 vin = 1'b0;
        repeat (7) @(negedge CLK);
        for (int d = 0; d < 4; d++) xs[d] = sbq[d].pop_front();
        for (int c = 0; c < 10; c++) begin
            for (int d = 0; d < 4; d++) begin
                n_checks += 4;
                if (vld[d] !== 1'b1)   begin n_fail++; $display("FAIL bp_valid dut%0d cyc %0d got %b want 1", d, c, vld[d]); end
                if (vo[d] !== xs[d].v) begin n_fail++; $display("FAIL bp_value dut%0d cyc %0d got %h want %h", d, c, vo[d], xs[d].v); end
                if (ovf[d] !== xs[d].o) begin n_fail++; $display("FAIL bp_ovf dut%0d cyc %0d got %b want %b", d, c, ovf[d], xs[d].o); end
                if (rdy[d] !== 1'b0)   begin n_fail++; $display("FAIL bp_ready dut%0d cyc %0d got %b want 0", d, c, rdy[d]); end
            end
            vin  = ~vin;
            vals = {$urandom, $urandom, $urandom, $urandom};
        end
        vin = 1'b0; rin = 1'b1;
        @(negedge CLK);
        for (int d = 0; d < 4; d++) begin
            n_checks += 2;
            if (vld[d] !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid dut%0d got %b want 0", d, vld[d]); end
            if (rdy[d] !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready dut%0d got %b want 1", d, rdy[d]); end
        end
        test_txn("bp_next", fill(8'h03, 8'h05), 8'hF8);
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        vals = fill(8'h11, 8'h22); ext = 8'h08; vin = 1'b1; rin = 1'b1;
        @(posedge CLK); #1 vin = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        for (int d = 0; d < 4; d++) begin
            n_checks += 4;
            if (vld[d] !== 1'b0)  begin n_fail++; $display("FAIL midrst_valid dut%0d got %b want 0", d, vld[d]); end
            if (vo[d] !== 8'h00)  begin n_fail++; $display("FAIL midrst_value dut%0d got %h want 00", d, vo[d]); end
            if (ovf[d] !== 1'b0)  begin n_fail++; $display("FAIL midrst_ovf dut%0d got %b want 0", d, ovf[d]); end
            if (rdy[d] !== 1'b1)  begin n_fail++; $display("FAIL midrst_ready dut%0d got %b want 1", d, rdy[d]); end
        end
        test_txn("after_rst", fill(8'h02, 8'h02), 8'hF8);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_txn("half",     fill(8'h04, 8'h04), 8'hF8);
        test_txn("pos_sat",  fill(8'h10, 8'h10), 8'hF8);
        test_txn("neg_sat",  fill(8'hE0, 8'hE0), 8'hF8);
        test_txn("alt",      fill(8'h7F, 8'h81), 8'hF8);
        test_txn("bias",     fill(8'h02, 8'h02), 8'hF8);
        test_txn("neg",      fill(8'hFC, 8'hFC), 8'hF8);
        test_txn("rand0",    {$urandom, $urandom, $urandom, $urandom}, 8'($urandom));
        test_txn("rand1",    {$urandom, $urandom, $urandom, $urandom}, 8'($urandom));
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
